bit_serializer32: RTL and testbench

//  Upstream sequencer for the mux32to1 bit-select datapath. Accepts a 32-bit word

---
 rtl/bit_serializer32_pkg.sv | 16 +
 rtl/bit_serializer32_mux.sv | 12 +
 rtl/bit_serializer32.sv | 73 +++++++
 tb/tb_bit_serializer32.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer32_pkg.sv
// Shared definitions for the bit serializer: state encoding, widths and start index.
package bit_serializer32_pkg;

  localparam int SEL_W  = 5;
  localparam int WORD_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] start_sel(input logic msb_first);
    return msb_first ? SEL_W'(WORD_W - 1) : '0;
  endfunction

endpackage

// File: rtl/bit_serializer32_mux.sv
// 32-to-1 bit-select mux: y is bit s of word i.
module bit_serializer32_mux
  import bit_serializer32_pkg::*;
(
  input  logic [SEL_W-1:0]  s,
  input  logic [WORD_W-1:0] i,
  output logic              y
);

  assign y = i[s];

endmodule

// File: rtl/bit_serializer32.sv
// Serializes a 32-bit word, LEN+1 bits long, onto a 1-bit valid/ready stream with LAST.
// Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module bit_serializer32
  import bit_serializer32_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] i_data,
  input  logic [SEL_W-1:0]  len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              dout,
  output logic              last,
  output logic [SEL_W-1:0]  sel,
  output state_t            state
);

  localparam logic [SEL_W-1:0] START = start_sel(MSB_FIRST);

  state_t             state_next;
  logic [WORD_W-1:0]  word;
  logic [SEL_W-1:0]   len_q;
  logic [SEL_W-1:0]   count;
  logic               accept;
  logic               step;

  always_comb begin
    state_next = state;
    out_valid  = (state == ST_SHIFT);
    last       = (state == ST_SHIFT) && (count == len_q);
    // Ready also opens on the final-bit handshake so words can run back-to-back.
    in_ready   = rst_n && ((state == ST_IDLE) || (out_ready && last));
    accept     = in_valid && in_ready;
    step       = out_valid && out_ready && !last;
    if (accept) begin
      state_next = ST_SHIFT;
    end else if (out_valid && out_ready && last) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      word  <= '0;
      len_q <= '0;
      count <= '0;
      sel   <= START;
    end else begin
      state <= state_next;
      if (accept) begin
        word  <= i_data;
        len_q <= len;
        count <= '0;
        sel   <= START;
      end else if (step) begin
        count <= count + 1'b1;
        sel   <= MSB_FIRST ? sel - 1'b1 : sel + 1'b1;
      end
    end
  end

  bit_serializer32_mux u_mux (
    .s (sel),
    .i (word),
    .y (dout)
  );

endmodule

// File: tb/tb_bit_serializer32.sv
// Bench for bit_serializer32: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a queue of expected bits built from each accepted word.
module tb_bit_serializer32;
  import bit_serializer32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] i_data = '0;
  logic [4:0]  len = '0;

  logic        in_ready_l, out_valid_l, dout_l, last_l;
  logic [4:0]  sel_l;
  state_t      state_l;
  logic        in_ready_m, out_valid_m, dout_m, last_m;
  logic [4:0]  sel_m;
  state_t      state_m;

  int n_tests = 0;
  int n_fail = 0;

  // Entries are {bit, sel, last}.
  logic [6:0] exp_l_q[$];
  logic [6:0] exp_m_q[$];
  logic [6:0] cap_l_q[$];
  logic [6:0] cap_m_q[$];

  bit_serializer32 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .i_data(i_data), .len(len), .out_valid(out_valid_l), .out_ready(out_ready),
    .dout(dout_l), .last(last_l), .sel(sel_l), .state(state_l)
  );

  bit_serializer32 #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .i_data(i_data), .len(len), .out_valid(out_valid_m), .out_ready(out_ready),
    .dout(dout_m), .last(last_m), .sel(sel_m), .state(state_m)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void load(input bit msb, input logic [31:0] d, input logic [4:0] n);
    for (int k = 0; k <= int'(n); k++) begin
      int idx;
      idx = msb ? 31 - k : k;
      if (msb) exp_m_q.push_back({d[idx], 5'(idx), k == int'(n)});
      else     exp_l_q.push_back({d[idx], 5'(idx), k == int'(n)});
    end
  endfunction

  task automatic check_unit(input bit msb, input string tag, input logic ir, input logic ov,
                            input logic d, input logic lst, input logic [4:0] s);
    int         sz;
    logic [6:0] head;
    logic       exp_ir;
    sz     = msb ? exp_m_q.size() : exp_l_q.size();
    head   = (sz > 0) ? (msb ? exp_m_q[0] : exp_l_q[0]) : 7'd0;
    exp_ir = (sz == 0) || (sz == 1 && out_ready);
    chk({tag, ".in_ready"}, 32'(ir), 32'(exp_ir));
    chk({tag, ".out_valid"}, 32'(ov), 32'(sz != 0));
    if (sz > 0) begin
      chk({tag, ".dout"}, 32'(d), 32'(head[6]));
      chk({tag, ".sel"}, 32'(s), 32'(head[5:1]));
      chk({tag, ".last"}, 32'(lst), 32'(head[0]));
      if (out_ready) begin
        if (msb) begin void'(exp_m_q.pop_front()); cap_m_q.push_back({d, s, lst}); end
        else     begin void'(exp_l_q.pop_front()); cap_l_q.push_back({d, s, lst}); end
      end
    end else begin
      chk({tag, ".last_idle"}, 32'(lst), 32'd0);
    end
    if (in_valid && exp_ir) load(msb, i_data, len);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst.in_ready_l", 32'(in_ready_l), 32'd0);
      chk("rst.in_ready_m", 32'(in_ready_m), 32'd0);
      chk("rst.out_valid_l", 32'(out_valid_l), 32'd0);
      chk("rst.out_valid_m", 32'(out_valid_m), 32'd0);
      chk("rst.last_l", 32'(last_l), 32'd0);
      chk("rst.last_m", 32'(last_m), 32'd0);
      chk("rst.dout_l", 32'(dout_l), 32'd0);
      chk("rst.sel_l", 32'(sel_l), 32'd0);
      chk("rst.sel_m", 32'(sel_m), 32'd31);
      exp_l_q.delete();
      exp_m_q.delete();
    end else begin
      check_unit(1'b0, "lsb", in_ready_l, out_valid_l, dout_l, last_l, sel_l);
      check_unit(1'b1, "msb", in_ready_m, out_valid_m, dout_m, last_m, sel_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input logic [4:0] n, input bit hold);
    int   waitc;
    logic acc;
    in_valid = 1'b1;
    i_data   = d;
    len      = n;
    waitc    = 0;
    acc      = 1'b0;
    while (!acc && waitc < 100) begin
      @(negedge clk);
      acc = in_ready_l;
      waitc++;
    end
    chk("send.accepted", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      i_data   = $urandom;
      len      = 5'($urandom);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp_l_q.size() != 0 || exp_m_q.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("wait_idle.drained", 32'(c < 200), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bits(input int base, input int n);
    int c;
    c = 0;
    while (cap_l_q.size() < base + n && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("wait_bits.reached", 32'(c < 200), 32'd1);
  endtask

  function automatic logic [31:0] collect(input bit msb, input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = msb ? cap_m_q[base + k][6] : cap_l_q[base + k][6];
    return v;
  endfunction

  function automatic int count_last(input bit msb, input int base);
    int c;
    c = 0;
    if (msb) begin
      for (int k = base; k < cap_m_q.size(); k++) c += int'(cap_m_q[k][0]);
    end else begin
      for (int k = base; k < cap_l_q.size(); k++) c += int'(cap_l_q[k][0]);
    end
    return c;
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int   bl, bm;
    logic acc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_release.in_ready_l", 32'(in_ready_l), 32'd1);
    chk("rst_release.in_ready_m", 32'(in_ready_m), 32'd1);
    out_ready = 1'b1;

    // Full word, 32 bits
    bl = cap_l_q.size(); bm = cap_m_q.size();
    send(32'hA5A5_0F0F, 5'd31, 1'b0);
    wait_idle();
    chk("full.lsb_bits", collect(1'b0, bl, 32), 32'hA5A5_0F0F);
    chk("full.msb_bits", collect(1'b1, bm, 32), 32'hF0F0_A5A5);
    chk("full.lsb_lasts", 32'(count_last(1'b0, bl)), 32'd1);
    chk("full.lsb_last_sel", 32'(cap_l_q[bl + 31][5:1]), 32'd31);

    // Partial word, 4 bits
    bl = cap_l_q.size(); bm = cap_m_q.size();
    send(32'h8000_0001, 5'd3, 1'b0);
    wait_idle();
    chk("part.lsb_bits", collect(1'b0, bl, 4), 32'h1);
    chk("part.msb_bits", collect(1'b1, bm, 4), 32'h1);
    chk("part.msb_last_sel", 32'(cap_m_q[bm + 3][5:1]), 32'd28);
    chk("part.msb_last_flag", 32'(cap_m_q[bm + 3][0]), 32'd1);
    chk("part.idle_l", 32'(state_l), 32'(ST_IDLE));

    // Backpressure at bit 3
    bl = cap_l_q.size(); bm = cap_m_q.size();
    send(32'h6D00_00B6, 5'd7, 1'b0);
    wait_bits(bl, 3);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    chk("stall.lsb_count", 32'(cap_l_q.size() - bl), 32'd8);
    chk("stall.lsb_bits", collect(1'b0, bl, 8), 32'hB6);
    chk("stall.msb_bits", collect(1'b1, bm, 8), 32'hB6);

    // Back-to-back: LEN=0 then LEN=1 with in_valid held high
    bl = cap_l_q.size(); bm = cap_m_q.size();
    send(32'h0000_0001, 5'd0, 1'b1);
    send(32'h0000_0002, 5'd1, 1'b0);
    wait_idle();
    chk("b2b.lsb_bits", collect(1'b0, bl, 3), 32'h5);
    chk("b2b.msb_bits", collect(1'b1, bm, 3), 32'h0);
    chk("b2b.lsb_lasts", 32'(count_last(1'b0, bl)), 32'd2);

    // Reset mid-word at bit 5
    bl = cap_l_q.size(); bm = cap_m_q.size();
    send(32'hDEAD_BEEF, 5'd31, 1'b0);
    wait_bits(bl, 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid_l", 32'(out_valid_l), 32'd0);
    chk("midrst.out_valid_m", 32'(out_valid_m), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst.no_last_l", 32'(count_last(1'b0, bl)), 32'd0);
    chk("midrst.no_last_m", 32'(count_last(1'b1, bm)), 32'd0);
    bl = cap_l_q.size(); bm = cap_m_q.size();
    send(32'hFFFF_FFFF, 5'd2, 1'b0);
    wait_idle();
    chk("midrst.restart_sel_l", 32'(cap_l_q[bl][5:1]), 32'd0);
    chk("midrst.restart_sel_m", 32'(cap_m_q[bm][5:1]), 32'd31);
    chk("midrst.restart_bits", collect(1'b0, bl, 3), 32'h7);

    // Randomized traffic with random backpressure
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready_l;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        if ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b1;
          i_data   = $urandom;
          len      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 4));
        end else begin
          in_valid = 1'b0;
          i_data   = $urandom;
          len      = 5'($urandom);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
